ahbl_apb3_bridge: RTL
=====================

// Module: ahbl_apb3_bridge
// PURPOSE
//  AHB-Lite slave to APB3 master bridge that sits directly downstream of the AHB-Lite BFM master in
//  the CoreGPIO simulation environment. It converts each single AHB-Lite transfer into one APB3
//  SETUP/ACCESS sequence on one of NSLOTS decoded peripheral selects, for example CoreGPIO.
//  It inserts AHB wait states until the APB access completes and maps PSLVERR, APB timeouts and
//  illegal sizes to a two-cycle AHB ERROR response.
// PARAMETERS
//  SLOT_AW   12   address bits per APB slot; the slot index is HADDR[SLOT_AW+3:SLOT_AW]
//  NSLOTS    16   number of PSEL outputs (1..16); any slot index >= NSLOTS gives ERROR with no APB access
//  TIMEOUT   255  maximum ACCESS cycles while waiting for PREADY; 0 disables the timeout
// PORTS
//  HCLK       in   1   single clock for the AHB and APB sides
//  HRESET     in   1   asynchronous reset, active-high
//  HSEL       in   1   slave select from the AHB decoder
//  HADDR      in   32  transfer address
//  HTRANS     in   2   transfer type; HTRANS[1]=1 means NONSEQ/SEQ (valid)
//  HWRITE     in   1   1 = write
//  HSIZE      in   3   transfer size; legal values are 0, 1 and 2
//  HWDATA     in   32  write data, valid in the first data-phase cycle
//  HREADY     in   1   bus-wide ready; a transfer is sampled only when this is 1
//  HREADYOUT  out  1   this slave is ready or completing
//  HRDATA     out  32  read data, registered
//  HRESP      out  1   1 = ERROR
//  PADDR      out  32  {HADDR[31:SLOT_AW] zeroed, HADDR[SLOT_AW-1:0]}
//  PSEL       out  NSLOTS  one-hot slot select
//  PENABLE    out  1   APB access phase
//  PWRITE     out  1   APB direction
//  PWDATA     out  32  APB write data
//  PRDATA     in   32  APB read data
//  PREADY     in   1   APB ready
//  PSLVERR    in   1   APB slave error, sampled when PREADY=1 in ACCESS
// BEHAVIOUR
//  Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0,
//   state=IDLE, timeout counter=0.
//  Reset acts immediately: asserting HRESET mid-transfer drops PSEL and PENABLE in the same cycle;
//   there is no pending completion after reset is released.
//  Accept: HSEL & HREADY & HTRANS[1] while state is IDLE or ERR2. This registers the address,
//   HWRITE, the slot index and a size-legal flag.
//  FSM states:
//   IDLE: HREADYOUT=1, HRESP=0.
//    Accept with a legal size and an in-range slot -> WDATA if write, else SETUP.
//    Accept with an illegal size or an out-of-range slot -> ERR1.
//   WDATA: HREADYOUT=0. Register PWDATA from HWDATA -> SETUP.
//   SETUP: PSEL[slot]=1, PENABLE=0, HREADYOUT=0 -> ACCESS.
//   ACCESS: PSEL[slot]=1, PENABLE=1, HREADYOUT=0.
//    PREADY & !PSLVERR -> IDLE. For reads, HRDATA <= PRDATA on this edge.
//    PREADY & PSLVERR -> ERR1. HRDATA is not updated.
//    TIMEOUT!=0 and the counter reaches TIMEOUT with PREADY=0 -> ERR1.
//   ERR1: HRESP=1, HREADYOUT=0, PSEL=0, PENABLE=0 -> ERR2.
//   ERR2: HRESP=1, HREADYOUT=1 -> IDLE, or accept a new transfer exactly as in IDLE.
//  Timeout counter: cleared on entry to ACCESS, increments each ACCESS cycle; saturating 8-bit width.
//  Latency (PREADY=1 on the first ACCESS cycle): 2 wait states for a read, 3 for a write.
//   The transfer completes in the IDLE cycle with HREADYOUT=1.
//  Outside SETUP/ACCESS: PSEL and PENABLE are 0. PADDR, PWRITE and PWDATA hold their last values.
//  HTRANS IDLE/BUSY with HSEL=1: OKAY response with zero wait states, no APB access.
//  HRDATA holds the last successful read value until the next successful read.
// TESTING
//  Read at 0x0000_1008 with PREADY=1 and PRDATA=0xA5A5_0001 ->
//   PSEL[1] high for 2 cycles, PADDR=0x008, HRDATA=0xA5A5_0001, 2 wait states, OKAY.
//  Write 0xDEAD_BEEF to 0x0000_3004 with PREADY held low 4 cycles ->
//   PWDATA=0xDEAD_BEEF, PSEL[3] for 6 cycles, 7 wait states, OKAY.
//  Read with PSLVERR=1 ->
//   HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1, then IDLE; HRDATA unchanged.
//  PREADY stuck at 0 with TIMEOUT=8 -> ACCESS ends after 8 cycles and a 2-cycle ERROR follows.
//  HSIZE=3 -> 2-cycle ERROR, PSEL stays 0.
//  Back-to-back NONSEQ write then read (second transfer sampled in the IDLE cycle) ->
//   both complete; second transfer sampled in the IDLE completion cycle; no dropped transfer.
//  HRESET pulsed during ACCESS -> PSEL=0, PENABLE=0, HREADYOUT=1 immediately.
//   A new read after reset completes normally.

Source files
------------

// File: rtl/ahbl_apb3_bridge.sv
// ahbl_apb3_bridge
//  AHB-Lite slave to APB3 master bridge. Each accepted single AHB transfer
//  becomes one APB SETUP/ACCESS sequence on the decoded slot select. AHB wait
//  states are held until the APB access completes. PSLVERR, ACCESS timeouts,
//  illegal sizes and out-of-range slots produce a two-cycle AHB ERROR response.
// Ports
//  HCLK, HRESET              clock, async active-high reset
//  HSEL..HREADY              AHB-Lite slave address/data phase inputs
//  HREADYOUT, HRDATA, HRESP  AHB-Lite slave response
//  PADDR..PWDATA             APB3 master request (PSEL one-hot, NSLOTS wide)
//  PRDATA, PREADY, PSLVERR   APB3 completer response
module ahbl_apb3_bridge #(
  parameter int SLOT_AW = 12,   // address bits per APB slot
  parameter int NSLOTS  = 16,   // PSEL width, 1..16
  parameter int TIMEOUT = 255   // max ACCESS cycles, 0 = no timeout, 1..255
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic [31:0]       HRDATA,
  output logic              HRESP,
  output logic [31:0]       PADDR,
  output logic [NSLOTS-1:0] PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [31:0]       PWDATA,
  input  logic [31:0]       PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
  } state_t;

  localparam logic [4:0] NSLOTS_C  = 5'(NSLOTS);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t            state, nstate;
  logic [3:0]        slot;
  logic [7:0]        tcnt;
  logic [7:0]        tcnt_inc;
  logic [NSLOTS-1:0] sel_dec;
  logic              accept, size_ok, slot_ok, legal, tmo_hit, rd_done;
  logic [3:0]        slot_in;

  // Address bits above the slot index do not take part in decoding.
  logic unused_haddr;
  assign unused_haddr = ^HADDR[31:SLOT_AW+4];

  assign slot_in = HADDR[SLOT_AW+3:SLOT_AW];
  assign accept  = HSEL & HREADY & HTRANS[1] & ((state == S_IDLE) | (state == S_ERR2));
  assign size_ok = (HSIZE[2] == 1'b0) & (HSIZE[1:0] != 2'b11);
  assign slot_ok = {1'b0, slot_in} < NSLOTS_C;
  assign legal   = size_ok & slot_ok;

  // Counter value at the end of the current ACCESS cycle, saturating at 255.
  assign tcnt_inc = (tcnt == 8'hFF) ? tcnt : tcnt + 8'd1;
  assign tmo_hit  = (TIMEOUT_C != 8'd0) & ~PREADY & (tcnt_inc >= TIMEOUT_C);
  assign rd_done  = (state == S_ACCESS) & PREADY & ~PSLVERR & ~PWRITE;

  for (genvar g = 0; g < NSLOTS; g++) begin : g_dec
    assign sel_dec[g] = (slot == 4'(g));
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= S_IDLE;
      tcnt  <= '0;
    end else begin
      state <= nstate;
      if (state == S_SETUP)       tcnt <= '0;
      else if (state == S_ACCESS) tcnt <= tcnt_inc;
    end
  end

  always_comb begin
    nstate    = state;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    PSEL      = '0;
    PENABLE   = 1'b0;
    case (state)
      S_IDLE, S_ERR2: begin
        HRESP = (state == S_ERR2);
        if (accept)              nstate = !legal ? S_ERR1 : (HWRITE ? S_WDATA : S_SETUP);
        else if (state == S_ERR2) nstate = S_IDLE;
      end
      S_WDATA: begin
        HREADYOUT = 1'b0;
        nstate    = S_SETUP;
      end
      S_SETUP: begin
        HREADYOUT = 1'b0;
        PSEL      = sel_dec;
        nstate    = S_ACCESS;
      end
      S_ACCESS: begin
        HREADYOUT = 1'b0;
        PSEL      = sel_dec;
        PENABLE   = 1'b1;
        if (PREADY)       nstate = PSLVERR ? S_ERR1 : S_IDLE;
        else if (tmo_hit) nstate = S_ERR1;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        nstate    = S_ERR2;
      end
      default: nstate = S_IDLE;
    endcase
  end

  // APB request fields only move on a legal accept, so they hold their last
  // value across error responses and idle periods.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      slot   <= '0;
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
      HRDATA <= '0;
    end else begin
      if (accept) slot <= slot_in;
      if (accept & legal) begin
        PADDR  <= {{(32-SLOT_AW){1'b0}}, HADDR[SLOT_AW-1:0]};
        PWRITE <= HWRITE;
      end
      if (state == S_WDATA) PWDATA <= HWDATA;
      if (rd_done)          HRDATA <= PRDATA;
    end
  end

endmodule
